// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a shared 1-bit alu, LSB first, one bit per clock.
// Define ALU_SEQ_B2B_EN to allow back-to-back requests straight out of DONE.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             abort,
    output logic [1:0]       alu_ctrl,
    output logic             alu_a,
    output logic             alu_b,
    input  logic             alu_y,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  sh_a_q;
    logic [WIDTH-1:0]  sh_b_q;
    logic [WIDTH-1:0]  res_q;
    logic [CW-1:0]     cnt_q;
    logic              zacc_q;
    logic              rzero_q;
    logic              in_run;
    logic              load;

    assign in_run = (state_q == RUN);

`ifdef ALU_SEQ_B2B_EN
    assign start_ready = (state_q == IDLE)
                       | ((state_q == DONE) & res_ready);
`else
    assign start_ready = (state_q == IDLE);
`endif

    assign load = start_valid & start_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            zacc_q  <= 1'b0;
            rzero_q <= 1'b0;
        end else if (load) begin
            // A DONE-state load also completes the pending result handshake.
            state_q <= RUN;
            op_q    <= op;
            sh_a_q  <= opa;
            sh_b_q  <= opb;
            cnt_q   <= '0;
            zacc_q  <= 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        res_q  <= {alu_y, res_q[WIDTH-1:1]};
                        sh_a_q <= {1'b0, sh_a_q[WIDTH-1:1]};
                        sh_b_q <= {1'b0, sh_b_q[WIDTH-1:1]};
                        zacc_q <= zacc_q & alu_zero;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                            rzero_q <= zacc_q & alu_zero;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign busy      = in_run;
    assign res_valid = (state_q == DONE);
    assign result    = res_q;
    assign res_zero  = rzero_q;
    assign alu_ctrl  = in_run ? op_q : 2'b00;
    assign alu_a     = in_run & sh_a_q[0];
    assign alu_b     = in_run & sh_b_q[0];

endmodule
